// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive front end: FSM encoding, default geometry
// and the counter-width helper used by the divider and slot counter.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } i2s_state_e;

    localparam int unsigned CLK_DIV_DEF     = 4;
    localparam int unsigned SLOT_BITS_DEF   = 32;
    localparam int unsigned SAMPLE_BITS_DEF = 32;

    // Bits needed for a counter running 0..n-1 (never less than one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_rx_frontend_if.sv
// Frame delivery bus between the I2S receive front end and its consumer.
interface i2s_rx_frontend_if
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF
) ();

    logic [2*SAMPLE_BITS-1:0] frame_o;
    logic                     frame_valid_o;
    logic                     frame_ready_i;
    logic                     overrun_o;
    logic                     overrun_clr_i;

    modport master (
        output frame_o, frame_valid_o, overrun_o,
        input  frame_ready_i, overrun_clr_i
    );

    modport slave (
        input  frame_o, frame_valid_o, overrun_o,
        output frame_ready_i, overrun_clr_i
    );

endinterface

// File: rtl/i2s_sck_gen.sv
// SCK generator: divides HCLK into the I2S bit clock and flags each SCK edge with a
// one-cycle tick aligned to the sck register update.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_sck,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int unsigned DW = cnt_w(CLK_DIV);

    logic [DW-1:0] r_cnt;
    logic          r_sck;
    logic          r_rise;
    logic          r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sck  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_sck  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (r_cnt == DW'(CLK_DIV - 1)) begin
            r_cnt  <= '0;
            r_sck  <= ~r_sck;
            r_rise <= ~r_sck;
            r_fall <= r_sck;
        end else begin
            r_cnt  <= r_cnt + DW'(1);
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign o_sck       = r_sck;
    assign o_rise_tick = r_rise;
    assign o_fall_tick = r_fall;

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S master receive front end: drives SCK/WS, deserialises Philips-format SD and
// hands one {right, left} frame per WS period to the consumer with overrun tracking.
module i2s_rx_frontend
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned SLOT_BITS   = SLOT_BITS_DEF,
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               en,
    input  logic               sd_i,
    output logic               sck_o,
    output logic               ws_o,
    i2s_rx_frontend_if.master  fr
);

    localparam int unsigned FRAME_SCK = 2 * SLOT_BITS;
    localparam int unsigned FW        = cnt_w(FRAME_SCK);
    localparam int unsigned LAST_P    = FRAME_SCK - 1;
    localparam int unsigned FB        = 2 * SAMPLE_BITS;

    i2s_state_e            r_state;
    i2s_state_e            w_state_nxt;
    logic                  w_run;
    logic                  w_rise;
    logic                  w_fall;
    logic [FW-1:0]         r_fcnt;
    logic [FW-1:0]         w_fcnt_nxt;
    logic [FW-1:0]         w_p;
    logic                  r_ws;
    logic [SAMPLE_BITS-1:0] r_left;
    logic [SAMPLE_BITS-1:0] r_right;
    logic [SAMPLE_BITS-1:0] w_left_nxt;
    logic [SAMPLE_BITS-1:0] w_right_nxt;
    logic [FB-1:0]         r_frame;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_cap;
    logic                  w_complete;
    logic                  w_emit;

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .i_run       (w_run),
        .o_sck       (sck_o),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    // Clocks stop in the same cycle en is seen low, not one state later
    assign w_run = en && (r_state != ST_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (!en)             w_state_nxt = ST_IDLE;
                else if (w_complete) w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (!en) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit position of the sample captured on this rise (one SCK behind WS)
    always_comb begin
        w_fcnt_nxt  = (r_fcnt == FW'(LAST_P)) ? '0 : r_fcnt + FW'(1);
        w_p         = (r_fcnt == '0) ? FW'(LAST_P) : r_fcnt - FW'(1);
        w_cap       = w_run && w_rise;
        w_left_nxt  = r_left;
        w_right_nxt = r_right;
        if (w_cap && (32'(w_p) < SAMPLE_BITS))
            w_left_nxt = {r_left[SAMPLE_BITS-2:0], sd_i};
        if (w_cap && (32'(w_p) >= SLOT_BITS) && (32'(w_p) < SLOT_BITS + SAMPLE_BITS))
            w_right_nxt = {r_right[SAMPLE_BITS-2:0], sd_i};
        w_complete  = w_cap && (32'(w_p) == LAST_P);
        w_emit      = w_complete && (r_state == ST_RUN);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fcnt  <= '0;
            r_ws    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
        end else if (!w_run) begin
            r_fcnt  <= '0;
            r_ws    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            if (w_fall) begin
                r_fcnt <= w_fcnt_nxt;
                r_ws   <= (32'(w_fcnt_nxt) >= SLOT_BITS);
            end
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
        end
    end

    // Output frame and handshake keep running while idle so a pending frame can drain
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_frame   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_emit) begin
                r_frame <= {w_right_nxt, w_left_nxt};
                r_valid <= 1'b1;
            end else if (r_valid && fr.frame_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_emit && r_valid && !fr.frame_ready_i)
                r_overrun <= 1'b1;
            else if (fr.overrun_clr_i)
                r_overrun <= 1'b0;
        end
    end

    assign ws_o             = r_ws;
    assign fr.frame_o       = r_frame;
    assign fr.frame_valid_o = r_valid;
    assign fr.overrun_o     = r_overrun;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Scoreboard bench for i2s_rx_frontend: a codec BFM serialises known frames, a monitor
// compares each delivered frame (32-bit and 24-bit sample instances) against the queue.
module tb_i2s_rx_frontend;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    logic en      = 1'b0;
    logic sd_i    = 1'b0;
    logic sck_o, ws_o, sck24, ws24;

    i2s_rx_frontend_if #(.SAMPLE_BITS(32)) bus ();
    i2s_rx_frontend_if #(.SAMPLE_BITS(24)) bus24 ();

    i2s_rx_frontend #(.CLK_DIV(2), .SLOT_BITS(32), .SAMPLE_BITS(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .sd_i(sd_i),
        .sck_o(sck_o), .ws_o(ws_o), .fr(bus)
    );

    i2s_rx_frontend #(.CLK_DIV(2), .SLOT_BITS(32), .SAMPLE_BITS(24)) dut24 (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .sd_i(sd_i),
        .sck_o(sck24), .ws_o(ws24), .fr(bus24)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tbl_l [4] = '{32'hA5A5_0001, 32'h1234_567F, 32'hFFFF_0000, 32'h0F0F_8001};
    logic [31:0] tbl_r [4] = '{32'h8000_00FF, 32'hCAFE_BEEF, 32'h0000_FFFF, 32'h7654_3210};

    logic [63:0] sb_q [$];
    logic [63:0] last_frame = '0;
    logic [31:0] cur_l = '0;
    logic [31:0] cur_r = '0;
    bit          pend = 1'b0;
    bit          rdy_on_emit = 1'b0;
    int          bc = 0;
    int          fi = 0;
    int          emit_cnt = 0;
    int          cyc = 0;
    int          sck_last = -1;
    int          ws_last = -1;
    int          sck_per = 0;
    int          ws_per = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Codec BFM: changes SD on each SCK fall, tracking the slot position itself
    initial begin
        int p;
        forever begin
            @(negedge sck_o);
            if (HRESETn && en) begin
                bc = (bc + 1) % 64;
                p  = (bc + 63) % 64;
                if (p == 0) begin
                    cur_l = tbl_l[fi % 4];
                    cur_r = tbl_r[fi % 4];
                end
                if (p < 32) sd_i = cur_l[31 - p];
                else        sd_i = cur_r[63 - p];
                if (p == 63) begin
                    sb_q.push_back({cur_r, cur_l});
                    fi++;
                    pend = 1'b1;
                end
            end
        end
    end

    // Monitor: a frame must be presented one HCLK after the right-LSB rise
    initial begin
        logic [63:0] exp;
        forever begin
            @(posedge sck_o);
            if (pend) begin
                pend = 1'b0;
                if (rdy_on_emit) begin
                    bus.frame_ready_i = 1'b1;
                    rdy_on_emit = 1'b0;
                end
                @(posedge HCLK);
                #1;
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 64'd0, 64'd1);
                end else begin
                    exp = sb_q.pop_front();
                    check_val("frame", bus.frame_o, exp);
                    check_val("valid", 64'(bus.frame_valid_o), 64'd1);
                    check_val("frame24", {16'h0, bus24.frame_o}, {16'h0, exp[63:40], exp[31:8]});
                    check_val("valid24", 64'(bus24.frame_valid_o), 64'd1);
                    last_frame = exp;
                end
                emit_cnt++;
            end
        end
    end

    // Period tracking and WS-edge alignment
    initial begin
        logic prev_sck = 1'b0;
        logic prev_ws  = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            cyc++;
            if (sck_o && !prev_sck) begin
                if (sck_last >= 0) sck_per = cyc - sck_last;
                sck_last = cyc;
            end
            if (ws_o && !prev_ws) begin
                if (ws_last >= 0) ws_per = cyc - ws_last;
                ws_last = cyc;
            end
            if (HRESETn && en && (ws_o !== prev_ws))
                check_val("ws_edge_sck_low", 64'(sck_o), 64'd0);
            prev_sck = sck_o;
            prev_ws  = ws_o;
        end
    end

    task automatic wait_emits(input int n);
        int target;
        int budget;
        target = emit_cnt + n;
        budget = 2000 * n;
        while (emit_cnt < target && budget > 0) begin
            @(negedge HCLK);
            budget--;
        end
        if (emit_cnt < target) check_val("emit_timeout", 64'(emit_cnt), 64'(target));
        @(negedge HCLK);
    endtask

    task automatic wait_bc(input int v);
        int budget;
        budget = 1000;
        while (bc != v && budget > 0) begin
            @(negedge HCLK);
            budget--;
        end
        if (bc != v) check_val("bc_timeout", 64'(bc), 64'(v));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_sck"},     64'(sck_o), 64'd0);
        check_val({tag, "_ws"},      64'(ws_o), 64'd0);
        check_val({tag, "_frame"},   bus.frame_o, 64'd0);
        check_val({tag, "_valid"},   64'(bus.frame_valid_o), 64'd0);
        check_val({tag, "_overrun"}, 64'(bus.overrun_o), 64'd0);
        check_val({tag, "_frame24"}, {16'h0, bus24.frame_o}, 64'd0);
    endtask

    initial begin
        int budget;
        bus.frame_ready_i   = 1'b0;
        bus.overrun_clr_i   = 1'b0;
        bus24.frame_ready_i = 1'b1;
        bus24.overrun_clr_i = 1'b0;
        repeat (3) @(negedge HCLK);
        check_zero("reset");
        HRESETn = 1'b1;

        // Basic streaming
        bus.frame_ready_i = 1'b1;
        en = 1'b1;
        wait_emits(3);
        check_val("sck_period", 64'(sck_per), 64'd4);
        check_val("ws_period", 64'(ws_per), 64'd256);
        check_val("valid_consumed", 64'(bus.frame_valid_o), 64'd0);

        // Backpressure across two completions
        bus.frame_ready_i = 1'b0;
        wait_emits(1);
        check_val("no_overrun_first", 64'(bus.overrun_o), 64'd0);
        wait_emits(1);
        check_val("overrun_set", 64'(bus.overrun_o), 64'd1);
        bus.overrun_clr_i = 1'b1;
        @(negedge HCLK);
        bus.overrun_clr_i = 1'b0;
        check_val("overrun_clr", 64'(bus.overrun_o), 64'd0);
        check_val("valid_kept", 64'(bus.frame_valid_o), 64'd1);
        rdy_on_emit = 1'b1;
        wait_emits(1);
        check_val("no_overrun_same_cycle", 64'(bus.overrun_o), 64'd0);
        check_val("valid_after_accept", 64'(bus.frame_valid_o), 64'd0);

        // Single-cycle ready pulse
        bus.frame_ready_i = 1'b0;
        wait_emits(1);
        check_val("pulse_pre_valid", 64'(bus.frame_valid_o), 64'd1);
        bus.frame_ready_i = 1'b1;
        @(negedge HCLK);
        bus.frame_ready_i = 1'b0;
        check_val("pulse_drop", 64'(bus.frame_valid_o), 64'd0);
        check_val("pulse_hold", bus.frame_o, last_frame);

        // Enable drop mid right slot with a pending frame
        wait_emits(1);
        wait_bc(40);
        repeat (2) @(negedge HCLK);
        check_val("pre_drop_ws", 64'(ws_o), 64'd1);
        en   = 1'b0;
        bc   = 0;
        pend = 1'b0;
        sb_q.delete();
        @(negedge HCLK);
        check_val("drop_sck", 64'(sck_o), 64'd0);
        check_val("drop_ws", 64'(ws_o), 64'd0);
        check_val("drop_valid_kept", 64'(bus.frame_valid_o), 64'd1);
        check_val("drop_frame_kept", bus.frame_o, last_frame);
        repeat (300) @(negedge HCLK);
        check_val("idle_sck", 64'(sck_o), 64'd0);
        check_val("idle_valid", 64'(bus.frame_valid_o), 64'd1);
        bus.frame_ready_i = 1'b1;
        @(negedge HCLK);
        check_val("idle_accept", 64'(bus.frame_valid_o), 64'd0);

        // Re-enable: first completion is discarded, then data resumes
        en = 1'b1;
        budget = 50;
        while (!sck_o && budget > 0) begin
            @(negedge HCLK);
            budget--;
        end
        check_val("reenable_sck", 64'(sck_o), 64'd1);
        repeat (3) @(negedge HCLK);
        check_val("sync_discard", 64'(bus.frame_valid_o), 64'd0);
        wait_emits(2);

        // Asynchronous reset between clock edges
        wait_bc(20);
        #3;
        HRESETn = 1'b0;
        en      = 1'b0;
        pend    = 1'b0;
        bc      = 0;
        sb_q.delete();
        #1;
        check_zero("async_rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check_val("post_rst_sck", 64'(sck_o), 64'd0);
        check_val("post_rst_valid", 64'(bus.frame_valid_o), 64'd0);
        en = 1'b1;
        wait_emits(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
